// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART stream adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Saturation value of the dropped-byte counter
  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  // Deasserted level of the active-low core strobes
  localparam logic STROBE_OFF = 1'b1;

  // Width of the post-access holdoff down-counter
  localparam int HOLD_CNT_W = 4;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_skid1.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_skid1
//  Description : One-entry receive holding register with valid/ready output.
//                A load is only requested while the entry is empty, so the
//                held byte is never overwritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_skid1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_load_perr,
  input  logic       i_load_ferr,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_perr,
  output logic       o_ferr
);

  logic       valid_q, valid_d;
  logic [7:0] data_q,  data_d;
  logic       perr_q,  perr_d;
  logic       ferr_q,  ferr_d;

  // Next-state: drain on handshake, fill on load
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_load_data;
      perr_d  = i_load_perr;
      ferr_d  = i_load_ferr;
    end
  end

  // Holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_perr  = perr_q;
  assign o_ferr  = ferr_q;

endmodule : uart_rx_skid1
`default_nettype wire

// File: rtl/uart_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_stream_adapter
//  Description : Bridges the UART core CSN/WEN/OEN strobe port to a TX
//                valid/ready input stream and an RX valid/ready output
//                stream. One access at a time, each followed by a holdoff
//                so the core flags settle. Errored RX bytes can be dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_stream_adapter
  import uart_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 2,    // legal range 1..15
  parameter bit          RX_PRIORITY    = 1'b1, // 1: read wins a tie
  parameter bit          DROP_ERR       = 1'b1  // 1: discard errored bytes
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       ovf_sticky,
  input  logic       ovf_clr,
  output logic [7:0] drop_cnt,
  output logic       uart_csn,
  output logic       uart_wen,
  output logic       uart_oen,
  output logic [7:0] uart_data_in,
  input  logic [7:0] uart_data_out,
  input  logic       uart_txrdy,
  input  logic       uart_rxrdy,
  input  logic       uart_parity_err,
  input  logic       uart_framing_err,
  input  logic       uart_overflow
);

  // Holdoff counter reload: HOLD spans exactly HOLDOFF_CYCLES cycles
  localparam logic [HOLD_CNT_W-1:0] c_hold_load = HOLD_CNT_W'(HOLDOFF_CYCLES - 1);

  state_e                state_q,    state_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  csn_q,      csn_d;
  logic                  wen_q,      wen_d;
  logic                  oen_q,      oen_d;
  logic [7:0]            data_in_q,  data_in_d;
  logic                  ovf_q,      ovf_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic w_read_elig;
  logic w_write_elig;
  logic w_sel_read;
  logic w_sel_write;
  logic w_rx_err;
  logic w_rx_load;

  assign w_read_elig  = uart_rxrdy & ~rx_valid;
  assign w_write_elig = tx_valid & uart_txrdy;
  assign w_sel_read   = w_read_elig  & (RX_PRIORITY  | ~w_write_elig);
  assign w_sel_write  = w_write_elig & (~RX_PRIORITY | ~w_read_elig);
  assign w_rx_err     = uart_parity_err | uart_framing_err;

  // Accept only from IDLE; gated by reset so nothing is taken while the
  // block is held in reset.
  assign tx_ready = RESET_N & (state_q == IDLE) & w_sel_write;

  // Sequencer next-state, strobes, overflow capture and drop counting
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    csn_d      = csn_q;
    wen_d      = wen_q;
    oen_d      = oen_q;
    data_in_d  = data_in_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_clr ? 1'b0 : ovf_q;
    w_rx_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_sel_read) begin
          state_d = READ;
          csn_d   = 1'b0;
          oen_d   = 1'b0;
        end else if (w_sel_write) begin
          state_d   = WRITE;
          csn_d     = 1'b0;
          wen_d     = 1'b0;
          data_in_d = tx_data;
        end
      end
      WRITE: begin
        csn_d      = STROBE_OFF;
        wen_d      = STROBE_OFF;
        state_d    = HOLD;
        hold_cnt_d = c_hold_load;
      end
      READ: begin
        csn_d      = STROBE_OFF;
        oen_d      = STROBE_OFF;
        state_d    = HOLD;
        hold_cnt_d = c_hold_load;
        // A fresh overflow beats a simultaneous clear
        if (uart_overflow) begin
          ovf_d = 1'b1;
        end
        if (DROP_ERR && w_rx_err) begin
          if (drop_cnt_q != DROP_CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end else begin
          w_rx_load = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and registered core-facing outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      csn_q      <= STROBE_OFF;
      wen_q      <= STROBE_OFF;
      oen_q      <= STROBE_OFF;
      data_in_q  <= 8'h00;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      csn_q      <= csn_d;
      wen_q      <= wen_d;
      oen_q      <= oen_d;
      data_in_q  <= data_in_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  uart_rx_skid1 u_rx_skid1 (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .i_load      (w_rx_load),
    .i_load_data (uart_data_out),
    .i_load_perr (DROP_ERR ? 1'b0 : uart_parity_err),
    .i_load_ferr (DROP_ERR ? 1'b0 : uart_framing_err),
    .i_ready     (rx_ready),
    .o_valid     (rx_valid),
    .o_data      (rx_data),
    .o_perr      (rx_perr),
    .o_ferr      (rx_ferr)
  );

  assign uart_csn     = csn_q;
  assign uart_wen     = wen_q;
  assign uart_oen     = oen_q;
  assign uart_data_in = data_in_q;
  assign ovf_sticky   = ovf_q;
  assign drop_cnt     = drop_cnt_q;

endmodule : uart_stream_adapter
`default_nettype wire

// File: tb/tb_uart_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_stream_adapter
//  Description : Directed self-checking bench. Instance a uses the default
//                parameters; instance b uses RX_PRIORITY=0, DROP_ERR=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_stream_adapter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       a_tx_valid = 1'b0, b_tx_valid = 1'b0;
  logic       a_rx_ready = 1'b0, b_rx_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] uart_data_out = 8'h00;
  logic       uart_txrdy = 1'b0, uart_rxrdy = 1'b0;
  logic       perr_in = 1'b0, ferr_in = 1'b0, ovf_in = 1'b0;

  logic       a_tx_ready, a_rx_valid, a_rx_perr, a_rx_ferr, a_ovf;
  logic       a_csn, a_wen, a_oen;
  logic [7:0] a_rx_data, a_drop_cnt, a_data_in;
  logic       b_tx_ready, b_rx_valid, b_rx_perr, b_rx_ferr, b_ovf;
  logic       b_csn, b_wen, b_oen;
  logic [7:0] b_rx_data, b_drop_cnt, b_data_in;

  int n_checks = 0;
  int n_fail   = 0;
  int inv_bad  = 0;
  logic saw_valid;

  always #5 CLK = ~CLK;

  uart_stream_adapter dut_a (
    .CLK(CLK), .RESET_N(RESET_N),
    .tx_data(tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_perr(a_rx_perr), .rx_ferr(a_rx_ferr),
    .ovf_sticky(a_ovf), .ovf_clr(ovf_clr), .drop_cnt(a_drop_cnt),
    .uart_csn(a_csn), .uart_wen(a_wen), .uart_oen(a_oen),
    .uart_data_in(a_data_in), .uart_data_out(uart_data_out),
    .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
    .uart_parity_err(perr_in), .uart_framing_err(ferr_in),
    .uart_overflow(ovf_in)
  );

  uart_stream_adapter #(
    .HOLDOFF_CYCLES(2), .RX_PRIORITY(1'b0), .DROP_ERR(1'b0)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N),
    .tx_data(tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_perr(b_rx_perr), .rx_ferr(b_rx_ferr),
    .ovf_sticky(b_ovf), .ovf_clr(ovf_clr), .drop_cnt(b_drop_cnt),
    .uart_csn(b_csn), .uart_wen(b_wen), .uart_oen(b_oen),
    .uart_data_in(b_data_in), .uart_data_out(uart_data_out),
    .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
    .uart_parity_err(perr_in), .uart_framing_err(ferr_in),
    .uart_overflow(ovf_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    a_tx_valid = 0; b_tx_valid = 0; a_rx_ready = 0; b_rx_ready = 0;
    ovf_clr = 0; uart_txrdy = 0; uart_rxrdy = 0;
    perr_in = 0; ferr_in = 0; ovf_in = 0; tx_data = 8'h00; uart_data_out = 8'h00;
    #1;
    check("rst_strobes", {a_csn, a_wen, a_oen, b_csn, b_wen, b_oen}, 6'h3F);
    check("rst_data_in", a_data_in, 8'h00);
    check("rst_flags", {a_tx_ready, a_rx_valid, a_rx_perr, a_rx_ferr, a_ovf}, 5'b0);
    check("rst_rx_data", a_rx_data, 8'h00);
    check("rst_drop_cnt", {a_drop_cnt, b_drop_cnt}, 16'h0000);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  // Strobe invariant: WEN/OEN never both low, CSN low iff one of them is
  always @(negedge CLK) begin
    if ((!a_wen && !a_oen) || (a_csn != (a_wen & a_oen))) inv_bad++;
    if ((!b_wen && !b_oen) || (b_csn != (b_wen & b_oen))) inv_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    // ---------------- TX write path ----------------
    do_reset();
    uart_txrdy = 1; tx_data = 8'hA5; a_tx_valid = 1; b_tx_valid = 1;
    smp();
    check("tx_ready_idle", a_tx_ready, 1);
    check("tx_idle_csn", a_csn, 1);
    nxt(); tx_data = 8'h5A;
    smp();
    check("wr_strobe", {a_csn, a_wen, a_oen}, 3'b001);
    check("wr_data", a_data_in, 8'hA5);
    check("wr_tx_ready_low", a_tx_ready, 0);
    for (int c = 2; c <= 4; c++) begin
      nxt(); smp();
      check("wr_gap_strobes", {a_csn, a_wen}, 2'b11);
      check("wr_gap_ready", a_tx_ready, (c == 4));
      check("wr_hold_data", a_data_in, 8'hA5);
    end
    nxt(); a_tx_valid = 0; b_tx_valid = 0;
    smp();
    check("wr2_strobe", {a_csn, a_wen}, 2'b00);
    check("wr2_data", a_data_in, 8'h5A);
    nxt(); uart_txrdy = 0; tx_data = 8'hC3; a_tx_valid = 1; b_tx_valid = 1;
    for (int c = 6; c <= 10; c++) begin
      smp();
      check("txrdy_low_ready", a_tx_ready, 0);
      check("txrdy_low_csn", a_csn, 1);
      nxt();
    end
    uart_txrdy = 1;
    smp();
    check("txrdy_rise_ready", a_tx_ready, 1);
    nxt(); a_tx_valid = 0; b_tx_valid = 0;
    smp();
    check("txrdy_rise_wr", {a_csn, a_wen, a_data_in}, {2'b00, 8'hC3});

    // ---------------- RX read path ----------------
    do_reset();
    uart_rxrdy = 1; uart_data_out = 8'h3C;
    smp();
    check("rd_idle_csn", a_csn, 1);
    nxt(); smp();
    check("rd_strobe", {a_csn, a_wen, a_oen}, 3'b010);
    check("rd_latency", a_rx_valid, 0);
    nxt(); uart_data_out = 8'hFF;
    smp();
    check("rd_valid", a_rx_valid, 1);
    check("rd_data", a_rx_data, 8'h3C);
    check("rd_flags", {a_rx_perr, a_rx_ferr}, 2'b00);
    for (int c = 3; c <= 8; c++) begin
      nxt(); smp();
      check("rd_blocked", {a_csn, a_rx_valid, a_rx_data}, {2'b11, 8'h3C});
    end
    nxt(); a_rx_ready = 1; b_rx_ready = 1;
    smp();
    nxt(); a_rx_ready = 0; b_rx_ready = 0; uart_rxrdy = 0;
    smp();
    check("rd_drained", {a_rx_valid, a_csn}, 2'b01);

    // ---------------- Simultaneous eligibility ----------------
    do_reset();
    uart_txrdy = 1; uart_rxrdy = 1; tx_data = 8'h11; uart_data_out = 8'h22;
    a_tx_valid = 1; b_tx_valid = 1;
    smp();
    check("pri_a_tx_ready", a_tx_ready, 0);
    check("pri_b_tx_ready", b_tx_ready, 1);
    nxt(); b_tx_valid = 0;
    smp();
    check("pri_a_first_read", {a_csn, a_wen, a_oen}, 3'b010);
    check("pri_b_first_write", {b_csn, b_wen, b_oen, b_data_in}, {3'b001, 8'h11});
    nxt(); nxt(); nxt();
    smp();
    check("pri_a_second_ready", a_tx_ready, 1);
    check("pri_a_rx_data", {a_rx_valid, a_rx_data}, {1'b1, 8'h22});
    nxt(); a_tx_valid = 0;
    smp();
    check("pri_a_second_write", {a_csn, a_wen, a_oen, a_data_in}, {3'b001, 8'h11});
    check("pri_b_second_read", {b_csn, b_wen, b_oen}, 3'b010);

    // ---------------- Parity error drop / forward ----------------
    do_reset();
    uart_rxrdy = 1; perr_in = 1; uart_data_out = 8'h77; a_rx_ready = 1; b_rx_ready = 0;
    smp(); nxt(); smp(); nxt();
    smp();
    check("drop_cnt_first", a_drop_cnt, 8'd1);
    check("perr_fwd", {b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_data}, {3'b110, 8'h77});
    check("perr_no_drop", b_drop_cnt, 8'd0);
    saw_valid = 1'b0;
    for (int c = 0; c < 1220; c++) begin
      nxt(); smp();
      if (a_rx_valid) saw_valid = 1'b1;
    end
    check("drop_never_valid", saw_valid, 1'b0);
    check("drop_saturate", a_drop_cnt, 8'hFF);

    // ---------------- Framing error drop / forward ----------------
    do_reset();
    uart_rxrdy = 1; ferr_in = 1; uart_data_out = 8'h99;
    smp(); nxt(); smp(); nxt();
    smp();
    check("ferr_drop", {a_rx_valid, a_drop_cnt}, {1'b0, 8'd1});
    check("ferr_fwd", {b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_data}, {3'b101, 8'h99});

    // ---------------- Overflow sticky ----------------
    do_reset();
    uart_rxrdy = 1; ovf_in = 1; uart_data_out = 8'h42;
    smp();
    nxt(); ovf_clr = 1;
    smp();
    check("ovf_not_yet", a_ovf, 0);
    nxt(); ovf_clr = 0; ovf_in = 0;
    smp();
    check("ovf_set_wins", a_ovf, 1);
    nxt(); smp();
    check("ovf_holds", a_ovf, 1);
    nxt(); ovf_clr = 1;
    smp();
    nxt(); ovf_clr = 0;
    smp();
    check("ovf_cleared", a_ovf, 0);

    // ---------------- Reset mid-WRITE ----------------
    do_reset();
    uart_txrdy = 1; tx_data = 8'hC3; a_tx_valid = 1;
    smp();
    nxt();
    smp();
    check("mid_wr_active", {a_csn, a_wen}, 2'b00);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mid_wr_async", {a_csn, a_wen, a_oen}, 3'b111);
    check("mid_wr_data", a_data_in, 8'h00);
    check("mid_wr_tx_ready", a_tx_ready, 0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    smp();
    check("post_rst_idle", a_tx_ready, 1);
    nxt(); a_tx_valid = 0;
    smp();
    check("post_rst_write", {a_csn, a_wen, a_data_in}, {2'b00, 8'hC3});

    check("strobe_invariant", inv_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_stream_adapter
`default_nettype wire
